mmap_read_arbiter: RTL and testbench
====================================

// Module: mmap_read_arbiter
// PURPOSE
// Shares one async_mmap read user interface (read_addr push / read_data pop) among
// NumPorts requesters. Round-robin arbitration on addresses; a tag FIFO records the
// granted port per address so in-order read data returns to the correct requester.
// Sits between task-side read ports and the async_mmap read_addr/read_data FIFOs.
// PARAMETERS
// NumPorts     4    number of requesters (>=2, need not be a power of 2)
// NumPortsLog  2    tag width, ceil(log2(NumPorts))
// AddrWidth    64   byte address width
// DataWidth    512  read data width
// TagDepth     64   max outstanding reads (tag FIFO depth)
// TagDepthLog  6    log2(TagDepth)
// PORTS
// clk                input  1                    clock
// rst                input  1                    synchronous reset, active high
// req_addr_din       input  NumPorts*AddrWidth   port i address at [i*AddrWidth +: AddrWidth]
// req_addr_write     input  NumPorts             port i pushes address
// req_addr_full_n    output NumPorts             port i may push
// resp_data_dout     output NumPorts*DataWidth   port i data at [i*DataWidth +: DataWidth]
// resp_data_empty_n  output NumPorts             port i data valid
// resp_data_read     input  NumPorts             port i pops data
// read_addr_din      output AddrWidth            to async_mmap read address
// read_addr_write    output 1                    push to async_mmap
// read_addr_full_n   input  1                    async_mmap accepts address
// read_data_dout     input  DataWidth            from async_mmap read data
// read_data_empty_n  input  1                    async_mmap data available
// read_data_read     output 1                    pop from async_mmap
// BEHAVIOUR
// - Reset: all in_valid/out_valid cleared, rr pointer=0, tag FIFO empty;
//   req_addr_full_n=all 1s, resp_data_empty_n=0, read_addr_write=0, read_data_read=0.
// - Input stage: per port 1-entry register {in_valid, in_addr}. A push is taken only
//   when req_addr_write[i] && req_addr_full_n[i]; pushes while full_n=0 are ignored.
// - req_addr_full_n[i] = ~in_valid[i] | grant[i]; grant never depends on
//   req_addr_write, so there is no combinational loop. Granted port refills same cycle.
// - Arbitration (combinational): issue = read_addr_full_n & tag_not_full & |in_valid.
//   grant = first in_valid port scanning rr, rr+1, ... NumPorts-1, 0, ... (wrap mod
//   NumPorts). One grant per cycle max; no grant when issue=0.
// - On grant to i: read_addr_write=1, read_addr_din=in_addr[i], push tag i, clear
//   in_valid[i] (unless refilled), rr <= (i==NumPorts-1) ? 0 : i+1. No grant: rr holds.
// - Latency: address pushed at cycle t appears on read_addr_din at t+1 if uncontended.
// - Tag FIFO: TagDepth entries, count register 0..TagDepth; tag_not_full = count!=TagDepth.
//   Simultaneous push and pop leave count unchanged; pointers wrap at TagDepth.
// - Response: h = tag FIFO head. pop = read_data_empty_n & tag_not_empty &
//   (~out_valid[h] | resp_data_read[h]). read_data_read=pop; on pop, out_data[h] <=
//   read_data_dout, out_valid[h] <= 1, tag popped, same cycle.
// - resp_data_empty_n[i] = out_valid[i]; out_valid[i] clears on read without refill.
// - read_data_empty_n with tag FIFO empty is a protocol error: data is not popped.
// - Head-of-line: a stalled requester blocks data for all ports (in-order return).
// - rst mid-operation drops buffered addresses, tags and data; caller resets async_mmap.
// TESTING
// - Reset, then idle: full_n=4'b1111, empty_n=0, read_addr_write=0 for 10 cycles.
// - Ports 0..3 push 0x000,0x100,0x200,0x300 same cycle -> read_addr_din issues
//   0x000,0x100,0x200,0x300 on consecutive cycles; data D0..D3 returns to ports 0..3.
// - Port 2 pushes every cycle, others idle -> one address per cycle, full_n[2] stays 1.
// - read_addr_full_n=0 for 5 cycles with all ports valid -> no write, full_n=0 for all;
//   on release grants resume from current rr, order unchanged.
// - TagDepth=4, data withheld: 4 grants then read_addr_write=0 until one data popped.
// - Port 1 holds resp_data_read=0, head tag=1 with tag 3 queued -> read_data_read=0,
//   port 3 gets no data until port 1 pops.

Source files
------------

// File: rtl/mmap_read_arbiter.sv
// mmap_read_arbiter
// Lets NumPorts requesters share one async_mmap read channel. Each port has a
// one-entry address buffer. A round-robin arbiter issues at most one address per
// cycle. A tag FIFO records which port owns each outstanding read, so in-order
// read data is steered back to the port that asked for it.
module mmap_read_arbiter #(
  parameter int NumPorts    = 4,
  parameter int NumPortsLog = 2,
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 512,
  parameter int TagDepth    = 64,
  parameter int TagDepthLog = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
  input  logic [NumPorts-1:0]           req_addr_write,
  output logic [NumPorts-1:0]           req_addr_full_n,
  output logic [NumPorts*DataWidth-1:0] resp_data_dout,
  output logic [NumPorts-1:0]           resp_data_empty_n,
  input  logic [NumPorts-1:0]           resp_data_read,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  input  logic                          read_data_empty_n,
  output logic                          read_data_read
);

  localparam logic [NumPortsLog:0]   NumPortsExt = (NumPortsLog+1)'(NumPorts);
  localparam logic [NumPortsLog-1:0] LastPort    = NumPortsLog'(NumPorts-1);
  localparam logic [TagDepthLog:0]   TagDepthExt = (TagDepthLog+1)'(TagDepth);
  localparam logic [TagDepthLog-1:0] LastTag     = TagDepthLog'(TagDepth-1);

  logic [NumPorts-1:0]           in_valid_q;
  logic [AddrWidth-1:0]          in_addr_q [NumPorts];
  logic [NumPortsLog-1:0]        rr_q, rr_d;

  logic [NumPortsLog-1:0]        tag_mem_q [TagDepth];
  logic [TagDepthLog-1:0]        tag_wr_q, tag_rd_q;
  logic [TagDepthLog:0]          tag_cnt_q, tag_cnt_d;

  logic [NumPorts-1:0]           out_valid_q;
  logic [NumPorts*DataWidth-1:0] out_data_q;

  logic                          tag_not_full, tag_not_empty, issue;
  logic                          grant_vld, pop;
  logic [NumPorts-1:0]           grant;
  logic [NumPortsLog-1:0]        grant_idx, head;
  logic [NumPortsLog:0]          scan_idx;

  assign tag_not_full  = (tag_cnt_q != TagDepthExt);
  assign tag_not_empty = (tag_cnt_q != '0);
  assign issue         = read_addr_full_n & tag_not_full & (|in_valid_q);

  // Round-robin scan starting at rr_q; first valid port wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant     = '0;
    for (int k = 0; k < NumPorts; k++) begin
      scan_idx = {1'b0, rr_q} + (NumPortsLog+1)'(k);
      if (scan_idx >= NumPortsExt) scan_idx = scan_idx - NumPortsExt;
      if (issue && !grant_vld && in_valid_q[scan_idx[NumPortsLog-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[NumPortsLog-1:0];
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (grant_idx == LastPort) ? '0 : grant_idx + 1'b1;
  end

  // Grant does not depend on req_addr_write, so this path has no loop.
  assign req_addr_full_n = ~in_valid_q | grant;
  assign read_addr_write = grant_vld;
  assign read_addr_din   = in_addr_q[grant_idx];

  // Data pops only when the owning port can take it (head-of-line blocking).
  assign head           = tag_mem_q[tag_rd_q];
  assign pop            = read_data_empty_n & tag_not_empty &
                          (~out_valid_q[head] | resp_data_read[head]);
  assign read_data_read = pop;

  assign resp_data_empty_n = out_valid_q;
  assign resp_data_dout    = out_data_q;

  // Next tag count: a push and a pop in the same cycle cancel.
  always_comb begin
    tag_cnt_d = tag_cnt_q;
    case ({grant_vld, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Input buffers and arbitration pointer; a granted port may refill at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= '0;
      rr_q       <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (req_addr_write[i] && req_addr_full_n[i]) begin
          in_valid_q[i] <= 1'b1;
          in_addr_q[i]  <= req_addr_din[i*AddrWidth +: AddrWidth];
        end else if (grant[i]) begin
          in_valid_q[i] <= 1'b0;
        end
      end
      rr_q <= rr_d;
    end
  end

  // Tag storage; only the pointers and count need reset.
  always_ff @(posedge clk) begin
    if (grant_vld) tag_mem_q[tag_wr_q] <= grant_idx;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (grant_vld) tag_wr_q <= (tag_wr_q == LastTag) ? '0 : tag_wr_q + 1'b1;
      if (pop)       tag_rd_q <= (tag_rd_q == LastTag) ? '0 : tag_rd_q + 1'b1;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Per-port response registers: load on pop to this port, clear on read.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (pop && head == NumPortsLog'(i)) begin
          out_valid_q[i]                       <= 1'b1;
          out_data_q[i*DataWidth +: DataWidth] <= read_data_dout;
        end else if (resp_data_read[i]) begin
          out_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmap_read_arbiter.sv
// Directed bench for mmap_read_arbiter: 4 ports, 4-deep tag FIFO, 32-bit data.
module tb_mmap_read_arbiter;
  localparam int NP = 4;
  localparam int AW = 64;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*AW-1:0] req_addr_din;
  logic [NP-1:0]    req_addr_write;
  logic [NP-1:0]    req_addr_full_n;
  logic [NP*DW-1:0] resp_data_dout;
  logic [NP-1:0]    resp_data_empty_n;
  logic [NP-1:0]    resp_data_read;
  logic [AW-1:0]    read_addr_din;
  logic             read_addr_write;
  logic             read_addr_full_n;
  logic [DW-1:0]    read_data_dout;
  logic             read_data_empty_n;
  logic             read_data_read;

  int checks   = 0;
  int failures = 0;

  mmap_read_arbiter #(
    .NumPorts(NP), .NumPortsLog(2), .AddrWidth(AW), .DataWidth(DW),
    .TagDepth(4), .TagDepthLog(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr_din(req_addr_din), .req_addr_write(req_addr_write),
    .req_addr_full_n(req_addr_full_n),
    .resp_data_dout(resp_data_dout), .resp_data_empty_n(resp_data_empty_n),
    .resp_data_read(resp_data_read),
    .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
    .read_addr_full_n(read_addr_full_n),
    .read_data_dout(read_data_dout), .read_data_empty_n(read_data_empty_n),
    .read_data_read(read_data_read)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pdata(input int p);
    return resp_data_dout[p*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_addr_din = '0; req_addr_write = '0; resp_data_read = '0;
    read_addr_full_n = 1'b1; read_data_dout = '0; read_data_empty_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++;
      if (req_addr_full_n !== 4'hF || resp_data_empty_n !== 4'h0 ||
          read_addr_write !== 1'b0 || read_data_read !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: full_n=%b empty_n=%b raw=%b rdr=%b want 1111 0000 0 0",
                 k, req_addr_full_n, resp_data_empty_n, read_addr_write, read_data_read);
      end
    end
  endtask

  task automatic test_all_ports();
    logic [NP-1:0] exp_fn;
    @(negedge clk);
    for (int i = 0; i < NP; i++) req_addr_din[i*AW +: AW] = 64'(i * 256);
    req_addr_write = 4'hF;
    #1;
    checks++;
    if (req_addr_full_n !== 4'hF) begin
      failures++;
      $display("FAIL all_push_fulln: got %b want 1111", req_addr_full_n);
    end
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      req_addr_write = '0;
      #1;
      exp_fn = 4'((1 << (k + 1)) - 1);
      checks++;
      if (read_addr_write !== 1'b1 || read_addr_din !== 64'(k * 256) || req_addr_full_n !== exp_fn) begin
        failures++;
        $display("FAIL all_issue%0d: raw=%b din=%h full_n=%b want 1 %h %b",
                 k, read_addr_write, read_addr_din, req_addr_full_n, 64'(k * 256), exp_fn);
      end
    end
    @(negedge clk);
    read_data_empty_n = 1'b1; read_data_dout = 32'hD000_0000;
    #1;
    checks++;
    if (read_addr_write !== 1'b0 || read_data_read !== 1'b1) begin
      failures++;
      $display("FAIL all_data0: raw=%b rdr=%b want 0 1", read_addr_write, read_data_read);
    end
    for (int k = 1; k < NP; k++) begin
      @(negedge clk);
      read_data_dout = 32'hD000_0000 | 32'(k);
      #1;
      checks++;
      if (read_data_read !== 1'b1 || resp_data_empty_n !== 4'((1 << k) - 1) ||
          pdata(k - 1) !== (32'hD000_0000 | 32'(k - 1))) begin
        failures++;
        $display("FAIL all_data%0d: rdr=%b empty_n=%b prev=%h", k, read_data_read,
                 resp_data_empty_n, pdata(k - 1));
      end
    end
    @(negedge clk);
    read_data_empty_n = 1'b0; resp_data_read = 4'hF;
    #1;
    checks++;
    if (resp_data_empty_n !== 4'hF || read_data_read !== 1'b0 || pdata(0) !== 32'hD000_0000 ||
        pdata(1) !== 32'hD000_0001 || pdata(2) !== 32'hD000_0002 || pdata(3) !== 32'hD000_0003) begin
      failures++;
      $display("FAIL all_data_final: empty_n=%b rdr=%b data=%h want 1111 0 d0..d3",
               resp_data_empty_n, read_data_read, resp_data_dout);
    end
    @(negedge clk);
    resp_data_read = '0; read_data_empty_n = 1'b1;
    #1;
    checks++;
    if (resp_data_empty_n !== 4'h0 || read_data_read !== 1'b0) begin
      failures++;
      $display("FAIL no_tag_pop: empty_n=%b rdr=%b want 0000 0", resp_data_empty_n, read_data_read);
    end
    @(negedge clk);
    read_data_empty_n = 1'b0;
  endtask

  task automatic test_single_port();
    @(negedge clk);
    req_addr_write = 4'b0100; req_addr_din[2*AW +: AW] = 64'h2000;
    #1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        req_addr_write = 4'b0100; req_addr_din[2*AW +: AW] = 64'h2000 + 64'(k);
      end else begin
        req_addr_write = '0;
      end
      read_data_empty_n = 1'b1; resp_data_read = 4'b0100; read_data_dout = 32'hD200_0000 | 32'(k);
      #1;
      checks++;
      if (read_addr_write !== 1'b1 || read_addr_din !== 64'h2000 + 64'(k - 1) ||
          req_addr_full_n[2] !== 1'b1 || read_data_read !== (k >= 2)) begin
        failures++;
        $display("FAIL stream%0d: raw=%b din=%h full_n=%b rdr=%b", k, read_addr_write,
                 read_addr_din, req_addr_full_n, read_data_read);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (read_addr_write !== 1'b0 || read_data_read !== 1'b1) begin
      failures++;
      $display("FAIL stream_tail: raw=%b rdr=%b want 0 1", read_addr_write, read_data_read);
    end
    @(negedge clk);
    read_data_empty_n = 1'b0;
    @(negedge clk);
    resp_data_read = '0;
    #1;
    checks++;
    if (resp_data_empty_n !== 4'h0) begin
      failures++;
      $display("FAIL stream_drain: empty_n=%b want 0000", resp_data_empty_n);
    end
  endtask

  task automatic test_backpressure_tagfull();
    logic [AW-1:0] exp_din [4];
    logic [NP-1:0] exp_fn [4];
    exp_din = '{64'hA03, 64'hA00, 64'hA01, 64'hA02};
    exp_fn  = '{4'b1000, 4'b1001, 4'b1010, 4'b1110};
    @(negedge clk);
    read_addr_full_n = 1'b0; req_addr_write = 4'hF;
    for (int i = 0; i < NP; i++) req_addr_din[i*AW +: AW] = 64'hA00 + 64'(i);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_addr_write = '0;
      #1;
      checks++;
      if (read_addr_write !== 1'b0 || req_addr_full_n !== 4'h0) begin
        failures++;
        $display("FAIL stall%0d: raw=%b full_n=%b want 0 0000", k, read_addr_write, req_addr_full_n);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      read_addr_full_n = 1'b1;
      if (k == 1) begin
        req_addr_write = 4'b0001; req_addr_din[0 +: AW] = 64'hB00;
      end else begin
        req_addr_write = '0;
      end
      #1;
      checks++;
      if (read_addr_write !== 1'b1 || read_addr_din !== exp_din[k] || req_addr_full_n !== exp_fn[k]) begin
        failures++;
        $display("FAIL resume%0d: raw=%b din=%h full_n=%b want 1 %h %b", k, read_addr_write,
                 read_addr_din, req_addr_full_n, exp_din[k], exp_fn[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_addr_write = '0;
      #1;
      checks++;
      if (read_addr_write !== 1'b0 || req_addr_full_n !== 4'b1110) begin
        failures++;
        $display("FAIL tag_full%0d: raw=%b full_n=%b want 0 1110", k, read_addr_write, req_addr_full_n);
      end
    end
    @(negedge clk);
    read_data_empty_n = 1'b1; read_data_dout = 32'hD300_0000;
    #1;
    checks++;
    if (read_addr_write !== 1'b0 || read_data_read !== 1'b1) begin
      failures++;
      $display("FAIL tag_pop: raw=%b rdr=%b want 0 1", read_addr_write, read_data_read);
    end
    @(negedge clk);
    read_data_empty_n = 1'b0;
    #1;
    checks++;
    if (read_addr_write !== 1'b1 || read_addr_din !== 64'hB00 || req_addr_full_n !== 4'hF) begin
      failures++;
      $display("FAIL tag_freed: raw=%b din=%h full_n=%b want 1 b00 1111", read_addr_write,
               read_addr_din, req_addr_full_n);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      resp_data_read = 4'hF; read_data_empty_n = 1'b1;
      #1;
      checks++;
      if (read_data_read !== 1'b1) begin
        failures++;
        $display("FAIL drain%0d: rdr=%b want 1", k, read_data_read);
      end
    end
    @(negedge clk);
    read_data_empty_n = 1'b0;
    @(negedge clk);
    resp_data_read = '0;
    #1;
    checks++;
    if (resp_data_empty_n !== 4'h0) begin
      failures++;
      $display("FAIL drain_done: empty_n=%b want 0000", resp_data_empty_n);
    end
  endtask

  task automatic test_head_of_line();
    @(negedge clk);
    req_addr_write = 4'b0010; req_addr_din[1*AW +: AW] = 64'hC10;
    @(negedge clk);
    req_addr_din[1*AW +: AW] = 64'hC11;
    #1;
    checks++;
    if (read_addr_write !== 1'b1 || read_addr_din !== 64'hC10 || req_addr_full_n[1] !== 1'b1) begin
      failures++;
      $display("FAIL hol_issue0: raw=%b din=%h full_n=%b", read_addr_write, read_addr_din, req_addr_full_n);
    end
    @(negedge clk);
    req_addr_write = 4'b1000; req_addr_din[3*AW +: AW] = 64'hC30;
    #1;
    checks++;
    if (read_addr_write !== 1'b1 || read_addr_din !== 64'hC11) begin
      failures++;
      $display("FAIL hol_issue1: raw=%b din=%h want 1 c11", read_addr_write, read_addr_din);
    end
    @(negedge clk);
    req_addr_write = '0;
    #1;
    checks++;
    if (read_addr_write !== 1'b1 || read_addr_din !== 64'hC30) begin
      failures++;
      $display("FAIL hol_issue2: raw=%b din=%h want 1 c30", read_addr_write, read_addr_din);
    end
    @(negedge clk);
    read_data_empty_n = 1'b1; read_data_dout = 32'hE100_000A;
    #1;
    checks++;
    if (read_data_read !== 1'b1) begin
      failures++;
      $display("FAIL hol_first: rdr=%b want 1", read_data_read);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      read_data_dout = 32'hE100_000B;
      #1;
      checks++;
      if (read_data_read !== 1'b0 || resp_data_empty_n !== 4'b0010 || pdata(1) !== 32'hE100_000A) begin
        failures++;
        $display("FAIL hol_block%0d: rdr=%b empty_n=%b d1=%h want 0 0010 e100000a", k,
                 read_data_read, resp_data_empty_n, pdata(1));
      end
    end
    @(negedge clk);
    resp_data_read = 4'b0010;
    #1;
    checks++;
    if (read_data_read !== 1'b1) begin
      failures++;
      $display("FAIL hol_release: rdr=%b want 1", read_data_read);
    end
    @(negedge clk);
    resp_data_read = '0; read_data_dout = 32'hE300_0000;
    #1;
    checks++;
    if (read_data_read !== 1'b1 || pdata(1) !== 32'hE100_000B || resp_data_empty_n !== 4'b0010) begin
      failures++;
      $display("FAIL hol_port3_pop: rdr=%b d1=%h empty_n=%b want 1 e100000b 0010",
               read_data_read, pdata(1), resp_data_empty_n);
    end
    @(negedge clk);
    read_data_empty_n = 1'b0;
    #1;
    checks++;
    if (resp_data_empty_n !== 4'b1010 || pdata(3) !== 32'hE300_0000) begin
      failures++;
      $display("FAIL hol_port3_data: empty_n=%b d3=%h want 1010 e3000000", resp_data_empty_n, pdata(3));
    end
  endtask

  initial begin
    test_reset();
    test_all_ports();
    test_single_port();
    test_backpressure_tagfull();
    test_head_of_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
